// File: rtl/seg_reg_pkg.sv
// Shared definitions for the pipeline segment registers: default widths, the
// flush PC and the lane slicing helpers used by every bundle register.
package seg_reg_pkg;

  localparam int          SEG_XLEN     = 32;
  localparam logic [63:0] SEG_FLUSH_PC = 64'h0;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int lane_hi(input int lane, input int width);
    return lane * width + width - 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low clear; it sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_id_seg_bundle.sv
// IF/ID segment register for a multi-lane fetch bundle, with wrong-path lane
// squashing, flush-over-bubble priority and saturating bubble/flush counters.
module if_id_seg_bundle
  import seg_reg_pkg::*;
#(
  parameter int               XLEN     = SEG_XLEN,
  parameter int               LANES    = 2,
  parameter logic [XLEN-1:0]  FLUSH_PC = XLEN'(SEG_FLUSH_PC),
  parameter int               CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bubbleD,
  input  logic                  flushD,
  input  logic [LANES*XLEN-1:0] PC_IF,
  input  logic [LANES-1:0]      taken_IF,
  input  logic [LANES-1:0]      valid_IF,
  output logic [LANES*XLEN-1:0] PC_ID,
  output logic [LANES-1:0]      taken_ID,
  output logic [LANES-1:0]      valid_ID,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [LANES-1:0] kill;

  // A lane is wrong-path once any earlier lane is a valid predicted-taken branch.
  always_comb begin
    logic hit;
    hit  = 1'b0;
    kill = '0;
    for (int i = 0; i < LANES; i++) begin
      kill[i] = hit;
      hit     = hit | (valid_IF[i] & taken_IF[i]);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LO = lane_lo(i, XLEN);

    logic [XLEN-1:0] pc_q;
    logic            taken_q;
    logic            valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n || flushD) begin
        pc_q    <= FLUSH_PC;
        taken_q <= 1'b0;
        valid_q <= 1'b0;
      end else if (!bubbleD) begin
        pc_q    <= PC_IF[LO +: XLEN];
        taken_q <= taken_IF[i] & valid_IF[i];
        valid_q <= valid_IF[i] & ~kill[i];
      end
    end

    assign PC_ID[LO +: XLEN] = pc_q;
    assign taken_ID[i]       = taken_q;
    assign valid_ID[i]       = valid_q;
  end

  // A flush during a bubble counts only as a flush.
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubbleD & ~flushD),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flushD),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_seg_bundle.sv
// Self-checking bench for if_id_seg_bundle: directed scenarios plus a random
// run compared against a lane-level behavioural model.
module tb_if_id_seg_bundle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, bubbleD, flushD;

  logic [63:0]  pc_if2;  logic [1:0] tk_if2, vl_if2;
  logic [127:0] pc_if4;  logic [3:0] tk_if4, vl_if4;
  logic [31:0]  pc_if1;  logic [0:0] tk_if1, vl_if1;

  logic [63:0]  pc_id2;  logic [1:0] tk_id2, vl_id2;  logic [15:0] bc2, fc2;
  logic [63:0]  pc_ids;  logic [1:0] tk_ids, vl_ids;  logic [2:0]  bcs, fcs;
  logic [127:0] pc_id4;  logic [3:0] tk_id4, vl_id4;  logic [15:0] bc4, fc4;
  logic [31:0]  pc_id1;  logic [0:0] tk_id1, vl_id1;  logic [15:0] bc1, fc1;

  if_id_seg_bundle #(.LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bubbleD(bubbleD), .flushD(flushD),
    .PC_IF(pc_if2), .taken_IF(tk_if2), .valid_IF(vl_if2),
    .PC_ID(pc_id2), .taken_ID(tk_id2), .valid_ID(vl_id2),
    .bubble_cnt(bc2), .flush_cnt(fc2));

  if_id_seg_bundle #(.LANES(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bubbleD(bubbleD), .flushD(flushD),
    .PC_IF(pc_if2), .taken_IF(tk_if2), .valid_IF(vl_if2),
    .PC_ID(pc_ids), .taken_ID(tk_ids), .valid_ID(vl_ids),
    .bubble_cnt(bcs), .flush_cnt(fcs));

  if_id_seg_bundle #(.LANES(4), .FLUSH_PC(32'h0000_1000)) dut4 (
    .clk(clk), .rst_n(rst_n), .bubbleD(bubbleD), .flushD(flushD),
    .PC_IF(pc_if4), .taken_IF(tk_if4), .valid_IF(vl_if4),
    .PC_ID(pc_id4), .taken_ID(tk_id4), .valid_ID(vl_id4),
    .bubble_cnt(bc4), .flush_cnt(fc4));

  if_id_seg_bundle #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bubbleD(bubbleD), .flushD(flushD),
    .PC_IF(pc_if1), .taken_IF(tk_if1), .valid_IF(vl_if1),
    .PC_ID(pc_id1), .taken_ID(tk_id1), .valid_ID(vl_id1),
    .bubble_cnt(bc1), .flush_cnt(fc1));

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = 2-lane (dut2 and dut_sat), 1 = 4-lane, 2 = 1-lane.
  int          bc = 0, fc = 0;
  logic [31:0] m_pc [3][4];
  logic [3:0]  m_v  [3];
  logic [3:0]  m_t  [3];
  int          nl   [3] = '{2, 4, 1};
  logic [31:0] fpc  [3] = '{32'h0, 32'h0000_1000, 32'h0};

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge();
    logic [31:0] pin [4];
    logic [3:0]  vin, tin;
    int          first;
    if (!rst_n)        begin bc = 0; fc = 0; end
    else if (flushD)   fc++;
    else if (bubbleD)  bc++;
    for (int d = 0; d < 3; d++) begin
      vin = '0; tin = '0;
      for (int i = 0; i < 4; i++) pin[i] = '0;
      case (d)
        0: begin for (int i = 0; i < 2; i++) pin[i] = pc_if2[i*32 +: 32]; vin[1:0] = vl_if2; tin[1:0] = tk_if2; end
        1: begin for (int i = 0; i < 4; i++) pin[i] = pc_if4[i*32 +: 32]; vin = vl_if4; tin = tk_if4; end
        default: begin pin[0] = pc_if1; vin[0] = vl_if1[0]; tin[0] = tk_if1[0]; end
      endcase
      if (!rst_n || flushD) begin
        for (int i = 0; i < 4; i++) m_pc[d][i] = (i < nl[d]) ? fpc[d] : 32'h0;
        m_v[d] = '0; m_t[d] = '0;
      end else if (!bubbleD) begin
        // index of the earliest valid taken lane; lanes after it are wrong-path
        first = nl[d];
        for (int i = nl[d] - 1; i >= 0; i--) if (vin[i] && tin[i]) first = i;
        for (int i = 0; i < nl[d]; i++) begin
          m_pc[d][i] = pin[i];
          m_v[d][i]  = vin[i] && (i <= first);
          m_t[d][i]  = vin[i] && tin[i];
        end
      end
    end
  endtask

  function automatic logic [127:0] exp_pc(input int d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nl[d]; i++) r[i*32 +: 32] = m_pc[d][i];
    return r;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bubbleD = 1'b0; flushD = 1'b0;
    tick(); tick();
    checks++; if (pc_id2 !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_id2, 64'h0); end
    checks++; if (vl_id2 !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", vl_id2); end
    checks++; if (tk_id2 !== 2'b00) begin errors++; $display("FAIL reset_taken got=%b exp=00", tk_id2); end
    checks++; if (bc2 !== 16'd0 || fc2 !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bc2, fc2); end
    checks++; if (pc_id4 !== {4{32'h0000_1000}}) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", pc_id4, {4{32'h0000_1000}}); end
    rst_n = 1'b1;
    pc_if2 = {32'h104, 32'h100}; vl_if2 = 2'b11; tk_if2 = 2'b00;
    tick();
    checks++; if (pc_id2 !== {32'h104, 32'h100}) begin errors++; $display("FAIL load_pc got=%h exp=%h", pc_id2, {32'h104, 32'h100}); end
    checks++; if (vl_id2 !== 2'b11) begin errors++; $display("FAIL load_valid got=%b exp=11", vl_id2); end
  endtask

  task automatic test_taken_squash();
    vl_if2 = 2'b11; tk_if2 = 2'b01;
    tick();
    checks++; if (vl_id2 !== 2'b01) begin errors++; $display("FAIL squash_valid got=%b exp=01", vl_id2); end
    checks++; if (tk_id2 !== 2'b01) begin errors++; $display("FAIL squash_taken got=%b exp=01", tk_id2); end
    checks++; if (pc_id2[63:32] !== 32'h104) begin errors++; $display("FAIL squash_pc1 got=%h exp=104", pc_id2[63:32]); end
    vl_if2 = 2'b10; tk_if2 = 2'b01;
    tick();
    checks++; if (vl_id2 !== 2'b10) begin errors++; $display("FAIL invalid_taken_valid got=%b exp=10", vl_id2); end
    checks++; if (tk_id2 !== 2'b00) begin errors++; $display("FAIL invalid_taken_taken got=%b exp=00", tk_id2); end
  endtask

  task automatic test_bubble_hold();
    bubbleD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_if2 = {$urandom, $urandom}; vl_if2 = 2'($urandom); tk_if2 = 2'($urandom);
      tick();
      checks++;
      if (pc_id2 !== {32'h104, 32'h100} || vl_id2 !== 2'b10 || tk_id2 !== 2'b00) begin
        errors++; $display("FAIL bubble_hold%0d got=%h/%b/%b exp=%h/10/00", k, pc_id2, vl_id2, tk_id2, {32'h104, 32'h100});
      end
    end
    checks++; if (bc2 !== 16'd3) begin errors++; $display("FAIL bubble_cnt got=%0d exp=3", bc2); end
  endtask

  task automatic test_flush_bubble();
    bubbleD = 1'b1; flushD = 1'b1;
    pc_if2 = {32'h3000, 32'h2000}; vl_if2 = 2'b11; tk_if2 = 2'b00;
    tick();
    checks++; if (pc_id2 !== 64'h0 || vl_id2 !== 2'b00 || tk_id2 !== 2'b00) begin
      errors++; $display("FAIL flush_bubble got=%h/%b/%b exp=0/00/00", pc_id2, vl_id2, tk_id2); end
    checks++; if (fc2 !== 16'd1 || bc2 !== 16'd3) begin errors++; $display("FAIL flush_bubble_cnt got=%0d/%0d exp=1/3", fc2, bc2); end
    checks++; if (pc_id4 !== {4{32'h0000_1000}}) begin errors++; $display("FAIL flush_pc4 got=%h exp=%h", pc_id4, {4{32'h0000_1000}}); end
    flushD = 1'b0;
  endtask

  task automatic test_saturation();
    bubbleD = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (bcs !== 3'(sat(bc, 7))) begin errors++; $display("FAIL sat_step%0d got=%0d exp=%0d", k, bcs, sat(bc, 7)); end
    end
    checks++; if (bcs !== 3'd7 || bc2 !== 16'd13) begin errors++; $display("FAIL sat_final got=%0d/%0d exp=7/13", bcs, bc2); end
    rst_n = 1'b0;
    tick();
    checks++; if (bcs !== 3'd0 || bc2 !== 16'd0) begin errors++; $display("FAIL sat_reset got=%0d/%0d exp=0/0", bcs, bc2); end
    rst_n = 1'b1;
    tick();
    checks++; if (pc_id2 !== 64'h0 || vl_id2 !== 2'b00 || bc2 !== 16'd1) begin
      errors++; $display("FAIL reset_mid_bubble got=%h/%b/%0d exp=0/00/1", pc_id2, vl_id2, bc2); end
    bubbleD = 1'b0;
    pc_if2 = {32'h20c, 32'h208}; vl_if2 = 2'b11; tk_if2 = 2'b00;
    tick();
    checks++; if (pc_id2 !== {32'h20c, 32'h208} || vl_id2 !== 2'b11) begin
      errors++; $display("FAIL load_after_bubble got=%h/%b exp=%h/11", pc_id2, vl_id2, {32'h20c, 32'h208}); end
  endtask

  task automatic test_params();
    bubbleD = 1'b0; flushD = 1'b0;
    pc_if4 = {32'h4c, 32'h48, 32'h44, 32'h40}; vl_if4 = 4'b1111; tk_if4 = 4'b0100;
    pc_if1 = 32'h80; vl_if1 = 1'b1; tk_if1 = 1'b1;
    tick();
    checks++; if (vl_id4 !== 4'b0111 || tk_id4 !== 4'b0100) begin errors++; $display("FAIL lanes4 got=%b/%b exp=0111/0100", vl_id4, tk_id4); end
    checks++; if (pc_id4 !== {32'h4c, 32'h48, 32'h44, 32'h40}) begin errors++; $display("FAIL lanes4_pc got=%h", pc_id4); end
    checks++; if (vl_id1 !== 1'b1 || tk_id1 !== 1'b1 || pc_id1 !== 32'h80) begin
      errors++; $display("FAIL lanes1 got=%b/%b/%h exp=1/1/80", vl_id1, tk_id1, pc_id1); end
  endtask

  task automatic test_random();
    logic [127:0] e0, e1, e2;
    for (int k = 0; k < 300; k++) begin
      rst_n   = ($urandom_range(0, 39) != 0);
      flushD  = ($urandom_range(0, 7) == 0);
      bubbleD = ($urandom_range(0, 2) == 0);
      pc_if2 = {$urandom, $urandom}; vl_if2 = 2'($urandom); tk_if2 = 2'($urandom);
      pc_if4 = {$urandom, $urandom, $urandom, $urandom}; vl_if4 = 4'($urandom); tk_if4 = 4'($urandom);
      pc_if1 = $urandom; vl_if1 = 1'($urandom); tk_if1 = 1'($urandom);
      tick();
      e0 = exp_pc(0); e1 = exp_pc(1); e2 = exp_pc(2);
      checks++;
      if (pc_id2 !== e0[63:0] || vl_id2 !== m_v[0][1:0] || tk_id2 !== m_t[0][1:0] ||
          pc_ids !== e0[63:0] || vl_ids !== m_v[0][1:0] || tk_ids !== m_t[0][1:0]) begin
        errors++; $display("FAIL rand2_%0d got=%h/%b/%b exp=%h/%b/%b", k, pc_id2, vl_id2, tk_id2, e0[63:0], m_v[0][1:0], m_t[0][1:0]);
      end
      checks++;
      if (pc_id4 !== e1 || vl_id4 !== m_v[1] || tk_id4 !== m_t[1]) begin
        errors++; $display("FAIL rand4_%0d got=%h/%b/%b exp=%h/%b/%b", k, pc_id4, vl_id4, tk_id4, e1, m_v[1], m_t[1]);
      end
      checks++;
      if (pc_id1 !== e2[31:0] || vl_id1 !== m_v[2][0:0] || tk_id1 !== m_t[2][0:0]) begin
        errors++; $display("FAIL rand1_%0d got=%h/%b/%b exp=%h/%b/%b", k, pc_id1, vl_id1, tk_id1, e2[31:0], m_v[2][0], m_t[2][0]);
      end
      checks++;
      if (bc2 !== 16'(sat(bc, 65535)) || fc2 !== 16'(sat(fc, 65535)) || bcs !== 3'(sat(bc, 7)) || fcs !== 3'(sat(fc, 7)) ||
          bc4 !== bc2 || fc4 !== fc2 || bc1 !== bc2 || fc1 !== fc2) begin
        errors++; $display("FAIL rand_cnt_%0d got=%0d/%0d sat=%0d/%0d exp=%0d/%0d", k, bc2, fc2, bcs, fcs, bc, fc);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; bubbleD = 1'b0; flushD = 1'b0;
    pc_if2 = '0; tk_if2 = '0; vl_if2 = '0;
    pc_if4 = '0; tk_if4 = '0; vl_if4 = '0;
    pc_if1 = '0; tk_if1 = '0; vl_if1 = '0;
    test_reset();
    test_taken_squash();
    test_bubble_hold();
    test_flush_bubble();
    test_saturation();
    test_params();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
